// File: rtl/vote_collector.sv
// Ballot front end for the three-input majority voter.
// Conditions the session/cast keys (2-FF sync + debounce + press pulse),
// synchronises the choice switches, and runs the IDLE/OPEN/CLOSED session
// machine that latches one ballot per voter per session.
module vote_collector #(
  parameter int DEB_CYCLES    = 240000,
  parameter int WINDOW_CYCLES = 120000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic [2:0] key_cast_n,
  input  logic [2:0] sw_choice,
  output logic       vote_a,
  output logic       vote_b,
  output logic       vote_c,
  output logic       ballot_valid,
  output logic       session_open,
  output logic [2:0] cast_flag
);

  // Debounce counter only needs to reach DEB_CYCLES-1.
  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Timer wide enough to hold WINDOW_CYCLES; a zero window disables timeout.
  localparam int TIMER_W = (WINDOW_CYCLES > 0) ? $clog2(WINDOW_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] WIN_LAST =
    (WINDOW_CYCLES > 0) ? TIMER_W'(WINDOW_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2
  } state_t;

  // Key bundle layout: bit3 = session key, bits2:0 = cast keys C/B/A.
  logic [3:0] key_p0;
  logic [3:0] key_p1;
  logic [2:0] sw_p0;
  logic [2:0] sw_p1;
  logic [3:0] deb_q;
  logic [3:0] press_q;

  logic         start_ev;
  logic [2:0]   cast_ev;
  logic         timeout;

  state_t               state_q;
  state_t               state_d;
  logic [2:0]           vote_q;
  logic [2:0]           vote_d;
  logic [2:0]           cast_q;
  logic [2:0]           cast_d;
  logic [2:0]           new_cast;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   timer_d;
  logic                 valid_q;
  logic                 open_q;

  // Two-stage synchronisers; keys idle at the released level so that reset
  // release never looks like a press to the debouncers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 4'hF;
      key_p1 <= 4'hF;
      sw_p0  <= 3'b000;
      sw_p1  <= 3'b000;
    end else begin
      key_p0 <= {key_start_n, key_cast_n};
      key_p1 <= key_p0;
      sw_p0  <= sw_choice;
      sw_p1  <= sw_p0;
    end
  end

  // One debouncer per key: accept a new level after it has disagreed with
  // the current debounced level for DEB_CYCLES consecutive cycles.
  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic [DEB_W-1:0] cnt_q;

    // Debounce counter, debounced level and one-cycle press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q      <= '0;
        deb_q[g]   <= 1'b1;
        press_q[g] <= 1'b0;
      end else begin
        press_q[g] <= 1'b0;
        if (key_p1[g] != deb_q[g]) begin
          if (cnt_q == DEB_LAST) begin
            cnt_q      <= '0;
            deb_q[g]   <= key_p1[g];
            press_q[g] <= ~key_p1[g];
          end else begin
            cnt_q <= cnt_q + DEB_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

  assign start_ev = press_q[3];
  assign cast_ev  = press_q[2:0];
  assign timeout  = (WINDOW_CYCLES != 0) && (timer_q == WIN_LAST);

  // Session next-state, ballot capture and window timer.
  always_comb begin
    state_d  = state_q;
    vote_d   = vote_q;
    cast_d   = cast_q;
    timer_d  = timer_q;
    new_cast = 3'b000;
    case (state_q)
      IDLE: begin
        vote_d  = 3'b000;
        cast_d  = 3'b000;
        timer_d = '0;
        if (start_ev) state_d = OPEN;
      end
      OPEN: begin
        // Only the first cast of each voter in a session is taken.
        new_cast = cast_ev & ~cast_q;
        vote_d   = (vote_q & ~new_cast) | (sw_p1 & new_cast);
        cast_d   = cast_q | new_cast;
        // Saturate so a disabled window never wraps the timer.
        if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
        if (start_ev || (&cast_d) || timeout) state_d = CLOSED;
      end
      CLOSED: begin
        if (start_ev) begin
          state_d = OPEN;
          vote_d  = 3'b000;
          cast_d  = 3'b000;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        vote_d  = 3'b000;
        cast_d  = 3'b000;
        timer_d = '0;
      end
    endcase
  end

  // Session registers; status flags are registered from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vote_q  <= 3'b000;
      cast_q  <= 3'b000;
      timer_q <= '0;
      valid_q <= 1'b0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vote_q  <= vote_d;
      cast_q  <= cast_d;
      timer_q <= timer_d;
      valid_q <= (state_d == CLOSED);
      open_q  <= (state_d == OPEN);
    end
  end

  assign vote_a       = vote_q[0];
  assign vote_b       = vote_q[1];
  assign vote_c       = vote_q[2];
  assign cast_flag    = cast_q;
  assign ballot_valid = valid_q;
  assign session_open = open_q;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector with short debounce and window.
module tb_vote_collector;

  logic       clk;
  logic       rst_n;
  logic       key_start_n;
  logic [2:0] key_cast_n;
  logic [2:0] sw_choice;
  logic       vote_a;
  logic       vote_b;
  logic       vote_c;
  logic       ballot_valid;
  logic       session_open;
  logic [2:0] cast_flag;

  // Packed view: {vote_a, vote_b, vote_c, ballot_valid, session_open, cast_flag}
  logic [7:0] obs;
  assign obs = {vote_a, vote_b, vote_c, ballot_valid, session_open, cast_flag};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int open_cyc  = -1;
  int close_cyc = -1;
  int open_cnt  = 0;
  logic so_prev = 1'b0;
  logic bv_prev = 1'b0;

  vote_collector #(
    .DEB_CYCLES    (4),
    .WINDOW_CYCLES (50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_start_n  (key_start_n),
    .key_cast_n   (key_cast_n),
    .sw_choice    (sw_choice),
    .vote_a       (vote_a),
    .vote_b       (vote_b),
    .vote_c       (vote_c),
    .ballot_valid (ballot_valid),
    .session_open (session_open),
    .cast_flag    (cast_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge monitor: cycle stamps of session_open / ballot_valid rising edges.
  always @(negedge clk) begin
    if (session_open && !so_prev) begin
      open_cyc = cyc;
      open_cnt = open_cnt + 1;
    end
    if (ballot_valid && !bv_prev) close_cyc = cyc;
    so_prev = session_open;
    bv_prev = ballot_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mask bit3 = session key, bits2:0 = cast keys; held long enough to debounce.
  task automatic press(input logic [3:0] mask);
    key_cast_n  = ~mask[2:0];
    key_start_n = ~mask[3];
    tick(6);
    key_cast_n  = 3'b111;
    key_start_n = 1'b1;
    tick(7);
  endtask

  task automatic test_reset;
    int nz;
    rst_n       = 1'b0;
    key_start_n = 1'b1;
    key_cast_n  = 3'b111;
    sw_choice   = 3'b000;
    tick(3);
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", obs, 8'h00);
    end
    rst_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (obs !== 8'h00) nz++;
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL idle_quiet nonzero_cycles=%0d want=0", nz);
    end
  endtask

  task automatic test_idle_ignore;
    press(4'b0111);
    press(4'b0001);
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL idle_cast_ignored got=%b want=%b", obs, 8'h00);
    end
  endtask

  task automatic test_full_ballot;
    sw_choice = 3'b101;
    press(4'b1000);
    total++;
    if (obs !== 8'b000_0_1_000) begin
      bad++;
      $display("FAIL full_open got=%b want=%b", obs, 8'b000_0_1_000);
    end
    press(4'b0001);
    total++;
    if (obs !== 8'b100_0_1_001) begin
      bad++;
      $display("FAIL full_cast_a got=%b want=%b", obs, 8'b100_0_1_001);
    end
    press(4'b0010);
    total++;
    if (obs !== 8'b100_0_1_011) begin
      bad++;
      $display("FAIL full_cast_b got=%b want=%b", obs, 8'b100_0_1_011);
    end
    press(4'b0100);
    total++;
    if (obs !== 8'b101_1_0_111) begin
      bad++;
      $display("FAIL full_autoclose got=%b want=%b", obs, 8'b101_1_0_111);
    end
  endtask

  task automatic test_start_close;
    sw_choice = 3'b011;
    press(4'b1000);
    total++;
    if (obs !== 8'b000_0_1_000) begin
      bad++;
      $display("FAIL reopen_clear got=%b want=%b", obs, 8'b000_0_1_000);
    end
    press(4'b0001);
    press(4'b1000);
    total++;
    if (obs !== 8'b100_1_0_001) begin
      bad++;
      $display("FAIL start_close got=%b want=%b", obs, 8'b100_1_0_001);
    end
  endtask

  task automatic test_timeout;
    sw_choice = 3'b001;
    press(4'b1000);
    tick(3);
    press(4'b0001);
    total++;
    if (obs !== 8'b100_0_1_001) begin
      bad++;
      $display("FAIL to_first_cast got=%b want=%b", obs, 8'b100_0_1_001);
    end
    sw_choice = 3'b000;
    tick(3);
    press(4'b0001);
    total++;
    if (obs !== 8'b100_0_1_001) begin
      bad++;
      $display("FAIL to_second_cast got=%b want=%b", obs, 8'b100_0_1_001);
    end
    for (int i = 0; i < 60 && !ballot_valid; i++) tick(1);
    tick(2);
    total++;
    if ((close_cyc - open_cyc) !== 50) begin
      bad++;
      $display("FAIL to_window got=%0d cycles want=50", close_cyc - open_cyc);
    end
    total++;
    if (obs !== 8'b100_1_0_001) begin
      bad++;
      $display("FAIL to_closed got=%b want=%b", obs, 8'b100_1_0_001);
    end
  endtask

  task automatic test_glitch_bounce;
    int base;
    base = open_cnt;
    key_start_n = 1'b0;
    tick(2);
    key_start_n = 1'b1;
    tick(10);
    total++;
    if ((open_cnt - base) !== 0 || obs !== 8'b100_1_0_001) begin
      bad++;
      $display("FAIL glitch opens=%0d obs=%b want opens=0 obs=%b",
               open_cnt - base, obs, 8'b100_1_0_001);
    end
    for (int i = 0; i < 10; i++) begin
      key_start_n = i[0];
      tick(1);
    end
    key_start_n = 1'b0;
    tick(8);
    key_start_n = 1'b1;
    tick(8);
    total++;
    if ((open_cnt - base) !== 1) begin
      bad++;
      $display("FAIL bounce_events got=%0d want=1", open_cnt - base);
    end
    total++;
    if (obs !== 8'b000_0_1_000) begin
      bad++;
      $display("FAIL bounce_state got=%b want=%b", obs, 8'b000_0_1_000);
    end
  endtask

  task automatic test_async_reset;
    sw_choice = 3'b010;
    press(4'b0010);
    total++;
    if (obs !== 8'b010_0_1_010) begin
      bad++;
      $display("FAIL pre_reset got=%b want=%b", obs, 8'b010_0_1_010);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", obs, 8'h00);
    end
    #10;
    rst_n = 1'b1;
    tick(3);
    press(4'b0010);
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=%b", obs, 8'h00);
    end
    press(4'b1000);
    total++;
    if (obs !== 8'b000_0_1_000) begin
      bad++;
      $display("FAIL post_reset_open got=%b want=%b", obs, 8'b000_0_1_000);
    end
  endtask

  task automatic test_reopen;
    sw_choice = 3'b111;
    press(4'b0100);
    press(4'b1000);
    total++;
    if (obs !== 8'b001_1_0_100) begin
      bad++;
      $display("FAIL reopen_closed got=%b want=%b", obs, 8'b001_1_0_100);
    end
    press(4'b1000);
    total++;
    if (obs !== 8'b000_0_1_000) begin
      bad++;
      $display("FAIL reopen_cleared got=%b want=%b", obs, 8'b000_0_1_000);
    end
  endtask

  task automatic test_back_to_back;
    sw_choice = 3'b110;
    press(4'b0111);
    total++;
    if (obs !== 8'b011_1_0_111) begin
      bad++;
      $display("FAIL simultaneous got=%b want=%b", obs, 8'b011_1_0_111);
    end
    sw_choice = 3'b001;
    press(4'b0111);
    total++;
    if (obs !== 8'b011_1_0_111) begin
      bad++;
      $display("FAIL closed_frozen got=%b want=%b", obs, 8'b011_1_0_111);
    end
  endtask

  initial begin
    test_reset;
    test_idle_ignore;
    test_full_ballot;
    test_start_close;
    test_timeout;
    test_glitch_bounce;
    test_async_reset;
    test_reopen;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
